rr_code_arbiter: RTL and testbench



---
 rtl/rr_code_arbiter.sv | 104 ++++++++++
 tb/tb_rr_code_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rr_code_arbiter.sv
// Round-robin arbiter over 7 request lines with a registered 3-bit channel code.
// Every grant change passes through an IDLE cycle (code=0); contested grants are capped at MAX_HOLD cycles.
module rr_code_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] req,
  output logic [2:0] code,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic [2:0] ptr_q, ptr_d;
  logic [2:0] cur_q, cur_d;
  logic [7:0] hold_q, hold_d;
  logic [2:0] code_q, code_d;
  logic       busy_q, busy_d;

  logic [2:0] sel;
  logic [6:0] others;
  logic       drop;

  // First set request at or after ptr, wrapping 6->0; lowest offset wins.
  always_comb begin
    logic [3:0] idx;
    sel = '0;
    for (int k = 6; k >= 0; k--) begin
      idx = {1'b0, ptr_q} + 4'(k);
      if (idx >= 4'd7) idx = idx - 4'd7;
      if (req[idx[2:0]]) sel = idx[2:0];
    end
  end

  assign others = req & ~(7'b1 << cur_q);
  assign drop   = !req[cur_q] || ((hold_q >= 8'(MAX_HOLD)) && (others != '0));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cur_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cur_q   <= cur_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cur_d   = cur_q;
    hold_d  = hold_q;
    case (state_q)
      IDLE: begin
        if (req != '0) begin
          state_d = GRANT;
          cur_d   = sel;
          hold_d  = 8'd1;
        end
      end
      GRANT: begin
        if (drop) begin
          // Release and pre-emption both hand lowest priority to the old holder.
          state_d = IDLE;
          ptr_d   = (cur_q == 3'd6) ? 3'd0 : cur_q + 3'd1;
          hold_d  = '0;
        end else if (hold_q < 8'(MAX_HOLD)) begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are derived from the next state and registered, so req never reaches them combinationally.
  always_comb begin
    code_d = '0;
    busy_d = 1'b0;
    if (state_d == GRANT) begin
      code_d = cur_d + 3'd1;
      busy_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      code_q <= '0;
      busy_q <= 1'b0;
    end else begin
      code_q <= code_d;
      busy_q <= busy_d;
    end
  end

  assign code = code_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_rr_code_arbiter.sv
// Bench for rr_code_arbiter: four instances (MAX_HOLD 1,2,3,8) share one request bus and are
// checked every cycle against a channel-level model, plus directed literal expectations.
module tb_rr_code_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] req = 7'h7F;
  logic [2:0] code [4];
  logic       busy [4];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  localparam int MH [4] = '{1, 2, 3, 8};

  always #5 clk = ~clk;

  rr_code_arbiter #(.MAX_HOLD(1)) u0 (.clk(clk), .rst(rst), .req(req), .code(code[0]), .busy(busy[0]));
  rr_code_arbiter #(.MAX_HOLD(2)) u1 (.clk(clk), .rst(rst), .req(req), .code(code[1]), .busy(busy[1]));
  rr_code_arbiter #(.MAX_HOLD(3)) u2 (.clk(clk), .rst(rst), .req(req), .code(code[2]), .busy(busy[2]));
  rr_code_arbiter #(.MAX_HOLD(8)) u3 (.clk(clk), .rst(rst), .req(req), .code(code[3]), .busy(busy[3]));

  // Model: owner is the granted channel or -1; nxt is the channel scanned first next time.
  int owner [4];
  int nxt   [4];
  int held  [4];

  always @(posedge clk) begin
    for (int m = 0; m < 4; m++) begin
      if (rst) begin
        owner[m] = -1; nxt[m] = 0; held[m] = 0;
      end else if (owner[m] < 0) begin
        for (int k = 0; k < 7; k++) begin
          if (owner[m] < 0 && req[(nxt[m] + k) % 7]) begin
            owner[m] = (nxt[m] + k) % 7;
            held[m]  = 1;
          end
        end
      end else begin
        int contenders;
        contenders = 0;
        for (int c = 0; c < 7; c++) if (c != owner[m] && req[c]) contenders++;
        if (!req[owner[m]] || (held[m] >= MH[m] && contenders > 0)) begin
          nxt[m]   = (owner[m] + 1) % 7;
          owner[m] = -1;
          held[m]  = 0;
        end else begin
          held[m] = (held[m] + 1 > MH[m]) ? MH[m] : held[m] + 1;
        end
      end
    end
    if (rst) chk_en <= 1'b1;
  end

  logic [2:0] prev [4];

  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 4; m++) begin
        total++;
        if (code[m] !== 3'(owner[m] + 1) || busy[m] !== (owner[m] >= 0)) begin
          bad++;
          $display("FAIL model inst%0d t=%0t code=%0d busy=%0d expected code=%0d busy=%0d",
                   m, $time, code[m], busy[m], owner[m] + 1, owner[m] >= 0);
        end
        total++;
        if (prev[m] != 3'd0 && code[m] != 3'd0 && code[m] != prev[m]) begin
          bad++;
          $display("FAIL bbm inst%0d t=%0t code %0d -> %0d without idle", m, $time, prev[m], code[m]);
        end
        prev[m] = code[m];
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
  endtask

  initial begin
    int seq1 [10];
    int seq0 [5];
    seq1 = '{1, 1, 0, 7, 7, 0, 1, 1, 0, 7};
    seq0 = '{1, 0, 7, 0, 1};
    for (int m = 0; m < 4; m++) prev[m] = 3'd0;

    // Reset held two edges with every request high.
    rst = 1'b1; req = 7'h7F;
    for (int j = 0; j < 2; j++) begin
      cyc(1);
      for (int m = 0; m < 4; m++) begin
        chk("rst_code", 8'(code[m]), 8'd0);
        chk("rst_busy", 8'(busy[m]), 8'd0);
      end
    end
    rst = 1'b0;
    cyc(1);
    for (int m = 0; m < 4; m++) chk("first_grant", 8'(code[m]), 8'd1);

    // Two contenders: rotation on MAX_HOLD=2 and MAX_HOLD=1.
    req = 7'b1000001;
    do_reset();
    for (int j = 0; j < 10; j++) begin
      cyc(1);
      chk("rot_mh2", 8'(code[1]), 8'(seq1[j]));
      if (j < 5) chk("rot_mh1", 8'(code[0]), 8'(seq0[j]));
    end

    // Single request and release, then ptr=3 picks channel 3 out of all.
    req = 7'h00; do_reset();
    req = 7'b0000100;
    for (int j = 0; j < 5; j++) begin
      cyc(1);
      chk("single_hold", 8'(code[3]), 8'd3);
    end
    req = 7'h00; cyc(1);
    chk("single_rel", 8'(code[3]), 8'd0);
    chk("single_rel_busy", 8'(busy[3]), 8'd0);
    req = 7'h7F; cyc(1);
    chk("ptr_after_ch2", 8'(code[3]), 8'd4);

    // Wrap search from ptr=6, then ptr=2 after channel 1 releases.
    req = 7'h00; do_reset();
    req = 7'b0100000; cyc(3);
    chk("ch5_grant", 8'(code[2]), 8'd6);
    req = 7'h00; cyc(1);
    req = 7'b0000010; cyc(1);
    chk("wrap_ptr6", 8'(code[2]), 8'd2);
    req = 7'h00; cyc(1);
    req = 7'h7F; cyc(1);
    chk("ptr_after_ch1", 8'(code[2]), 8'd3);

    // Scan from ptr=5 with only req[1].
    req = 7'h00; do_reset();
    req = 7'b0010000; cyc(2);
    req = 7'h00; cyc(1);
    req = 7'b0000010; cyc(1);
    chk("wrap_ptr5", 8'(code[2]), 8'd2);

    // Lone holder saturates, then pre-emption on MAX_HOLD=3.
    req = 7'h00; do_reset();
    req = 7'b0010000; cyc(1);
    for (int j = 0; j < 300; j++) begin
      if (code[2] != 3'd5) chk("lone_hold", 8'(code[2]), 8'd5);
      cyc(1);
    end
    chk("lone_hold_end", 8'(code[2]), 8'd5);
    req = 7'b0010001; cyc(1);
    chk("preempt_idle", 8'(code[2]), 8'd0);
    cyc(1);
    chk("preempt_next", 8'(code[2]), 8'd1);

    // Reset mid-grant on MAX_HOLD=8 restarts from ptr=0.
    req = 7'h00; do_reset();
    req = 7'b0000010; cyc(2);
    req = 7'h00; cyc(1);
    req = 7'b0001000; cyc(2);
    chk("mid_grant", 8'(code[3]), 8'd4);
    req = 7'b0001010; cyc(1);
    chk("mid_grant_hold", 8'(code[3]), 8'd4);
    rst = 1'b1; cyc(1);
    chk("mid_rst", 8'(code[3]), 8'd0);
    rst = 1'b0; cyc(1);
    chk("restart_ptr0", 8'(code[3]), 8'd2);

    // Random: slowly changing requests, occasional reset.
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(3) == 0) req[$urandom_range(6)] = ~req[$urandom_range(6)];
      if ($urandom_range(15) == 0) req = 7'($urandom);
      rst = ($urandom_range(199) == 0);
      cyc(1);
    end
    rst = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
